// File: rtl/prog_loader.sv
// prog_loader
//   Serial program loader and instruction store for the 4-bit CPU. A
//   16-instruction image arrives over a UART line (8N1) as:
//     0xA5 header, 16 data bytes, 8-bit checksum (sum of data mod 256).
//   Data is written into the inactive one of two 16x8 banks. A good checksum
//   swaps the banks, so a new image becomes visible all at once. A bad image
//   leaves the running program untouched. The CPU fetches through a
//   registered read port that is never stalled.
//
// Ports
//   clk       in   1  system clock
//   reset_n   in   1  synchronous active-low reset
//   rx        in   1  UART receive line, idle high, asynchronous to clk
//   adrs      in   4  instruction fetch address
//   dat_out   out  8  bank[active][adrs], one clk latency
//   cpu_hold  out  1  high while a frame is being received
//   load_ok   out  1  last frame committed (sticky)
//   load_err  out  1  last frame aborted (sticky)
module prog_loader #(
  parameter int CLKS_PER_BIT = 434,     // clk cycles per UART bit, >= 4
  parameter int TIMEOUT_CLKS = 1000000  // max idle clks between bytes in a frame
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx,
  input  logic [3:0] adrs,
  output logic [7:0] dat_out,
  output logic       cpu_hold,
  output logic       load_ok,
  output logic       load_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int GAP_W = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(TIMEOUT_CLKS - 1);
  localparam logic [7:0]       HEADER  = 8'hA5;

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_e;
  typedef enum logic [1:0] {F_IDLE, F_DATA, F_CSUM} frame_state_e;

  // ---------------------------------------------------------------------
  // rx synchronizer and falling-edge detector. Reset to the idle level so
  // leaving reset does not look like a start bit.
  // ---------------------------------------------------------------------
  logic rx_meta_q, rx_sync_q, rx_prev_q;

  // NOTE: clocked state is always assigned with <= so every register samples
  // the pre-edge values of the others; = here would collapse the FF chain.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  // ---------------------------------------------------------------------
  // Receiver FSM
  // ---------------------------------------------------------------------
  rx_state_e        r_state_q, r_state_d;
  logic [CNT_W-1:0] r_cnt_q, r_cnt_d;
  logic [2:0]       r_bit_q, r_bit_d;
  logic [7:0]       r_shift_q, r_shift_d;
  logic             byte_valid;
  logic             frame_err;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state_q <= R_IDLE;
      r_cnt_q   <= '0;
      r_bit_q   <= '0;
      r_shift_q <= '0;
    end else begin
      r_state_q <= r_state_d;
      r_cnt_q   <= r_cnt_d;
      r_bit_q   <= r_bit_d;
      r_shift_q <= r_shift_d;
    end
  end

  // NOTE: every output of a combinational block gets a default before the
  // case statement, so no path leaves a signal unassigned and no latch forms.
  always_comb begin
    r_state_d  = r_state_q;
    r_cnt_d    = r_cnt_q;
    r_bit_d    = r_bit_q;
    r_shift_d  = r_shift_q;
    byte_valid = 1'b0;
    frame_err  = 1'b0;
    unique case (r_state_q)
      R_IDLE: begin
        if (rx_prev_q && !rx_sync_q) begin
          r_state_d = R_START;
          r_cnt_d   = '0;
        end
      end
      R_START: begin
        // Mid start bit: a line already back high was only a glitch.
        if (r_cnt_q == HALF_M1) begin
          r_cnt_d   = '0;
          r_bit_d   = '0;
          r_state_d = rx_sync_q ? R_IDLE : R_DATA;
        end else begin
          r_cnt_d = r_cnt_q + 1'b1;
        end
      end
      R_DATA: begin
        if (r_cnt_q == FULL_M1) begin
          r_cnt_d   = '0;
          r_shift_d = {rx_sync_q, r_shift_q[7:1]};  // LSB first
          if (r_bit_q == 3'd7) r_state_d = R_STOP;
          else                 r_bit_d   = r_bit_q + 1'b1;
        end else begin
          r_cnt_d = r_cnt_q + 1'b1;
        end
      end
      R_STOP: begin
        if (r_cnt_q == FULL_M1) begin
          if (rx_sync_q) byte_valid = 1'b1;
          else           frame_err  = 1'b1;
          r_cnt_d   = '0;
          r_state_d = R_IDLE;
        end else begin
          r_cnt_d = r_cnt_q + 1'b1;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------
  frame_state_e     f_state_q, f_state_d;
  logic [3:0]       idx_q, idx_d;
  logic [7:0]       sum_q, sum_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             active_q, active_d;
  logic             hold_q, hold_d;
  logic             ok_q, ok_d;
  logic             err_q, err_d;
  logic             mem_we;
  logic             timeout;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      f_state_q <= F_IDLE;
      idx_q     <= '0;
      sum_q     <= '0;
      gap_q     <= '0;
      active_q  <= 1'b0;
      hold_q    <= 1'b0;
      ok_q      <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      f_state_q <= f_state_d;
      idx_q     <= idx_d;
      sum_q     <= sum_d;
      gap_q     <= gap_d;
      active_q  <= active_d;
      hold_q    <= hold_d;
      ok_q      <= ok_d;
      err_q     <= err_d;
    end
  end

  assign timeout = (f_state_q != F_IDLE) && (gap_q == GAP_MAX);

  always_comb begin
    f_state_d = f_state_q;
    idx_d     = idx_q;
    sum_d     = sum_q;
    gap_d     = (f_state_q == F_IDLE) ? '0 : gap_q + 1'b1;
    active_d  = active_q;
    hold_d    = hold_q;
    ok_d      = ok_q;
    err_d     = err_q;
    mem_we    = 1'b0;
    unique case (f_state_q)
      F_IDLE: begin
        if (byte_valid && r_shift_q == HEADER) begin
          hold_d    = 1'b1;
          ok_d      = 1'b0;
          err_d     = 1'b0;
          idx_d     = '0;
          sum_d     = '0;
          gap_d     = '0;
          f_state_d = F_DATA;
        end
      end
      F_DATA, F_CSUM: begin
        // Timeout wins over a byte completing in the same cycle.
        if (timeout || frame_err) begin
          err_d     = 1'b1;
          hold_d    = 1'b0;
          f_state_d = F_IDLE;
        end else if (byte_valid) begin
          gap_d = '0;
          if (f_state_q == F_DATA) begin
            mem_we = 1'b1;
            sum_d  = sum_q + r_shift_q;
            idx_d  = idx_q + 1'b1;
            if (idx_q == 4'd15) f_state_d = F_CSUM;
          end else begin
            if (r_shift_q == sum_q) begin
              active_d = ~active_q;
              ok_d     = 1'b1;
            end else begin
              err_d = 1'b1;
            end
            hold_d    = 1'b0;
            f_state_d = F_IDLE;
          end
        end
      end
      default: f_state_d = F_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Instruction banks and registered read port
  // ---------------------------------------------------------------------
  logic [7:0] bank_q [2][16];
  logic [7:0] dat_q;

  // NOTE: the banks are cleared by reset on purpose (a reset CPU must fetch
  // 0x00); that forces flops rather than a RAM macro, which is fine at 32x8.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < 16; i++) begin
          bank_q[b][i] <= '0;
        end
      end
      dat_q <= '0;
    end else begin
      if (mem_we) bank_q[~active_q][idx_q] <= r_shift_q;
      dat_q <= bank_q[active_q][adrs];
    end
  end

  assign dat_out  = dat_q;
  assign cpu_hold = hold_q;
  assign load_ok  = ok_q;
  assign load_err = err_q;

endmodule

// File: tb/tb_prog_loader.sv
module tb_prog_loader;

  localparam int CPB = 8;
  localparam int TMO = 500;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       rx;
  logic [3:0] adrs;
  logic [7:0] dat_out;
  logic       cpu_hold;
  logic       load_ok;
  logic       load_err;

  always #5 clk = ~clk;

  prog_loader #(.CLKS_PER_BIT(CPB), .TIMEOUT_CLKS(TMO)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .rx       (rx),
    .adrs     (adrs),
    .dat_out  (dat_out),
    .cpu_hold (cpu_hold),
    .load_ok  (load_ok),
    .load_err (load_err)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Reference model of both banks and the active selector.
  logic [7:0] model_bank [2][16];
  logic       model_active;

  // Scoreboards: expected read data and expected {load_ok, load_err}.
  logic [7:0] rd_q  [$];
  logic [1:0] res_q [$];

  // Advance n clocks and land 1 time unit after the edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < 16; i++)
        model_bank[b][i] = 8'h00;
    model_active = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(CPB);
    end
    rx = stop_bit;
    tick(CPB);
    rx = 1'b1;
    tick(2 * CPB);
  endtask

  // Reads all 16 addresses back to back; each sample must match the address
  // driven one clock earlier.
  task automatic read_all(input string tag);
    logic [7:0] exp;
    for (int a = 0; a < 16; a++) begin
      adrs = 4'(a);
      rd_q.push_back(model_bank[model_active][a]);
      tick(1);
      exp = rd_q.pop_front();
      n_total++;
      if (dat_out !== exp)
        $display("FAIL %s adrs=%0d: dat_out=%02h expected %02h", tag, a, dat_out, exp);
      else n_pass++;
    end
  endtask

  task automatic read_one(input logic [3:0] a, input logic [7:0] exp_val, input string tag);
    logic [7:0] exp;
    adrs = a;
    rd_q.push_back(exp_val);
    tick(1);
    exp = rd_q.pop_front();
    n_total++;
    if (dat_out !== exp)
      $display("FAIL %s: dat_out=%02h expected %02h", tag, dat_out, exp);
    else n_pass++;
  endtask

  // Waits (bounded) for cpu_hold to drop, then compares the sticky flags.
  task automatic wait_result(input int budget, input string tag);
    int k = 0;
    logic [1:0] exp;
    while (cpu_hold !== 1'b0 && k < budget) begin
      tick(1);
      k++;
    end
    n_total++;
    if (cpu_hold !== 1'b0)
      $display("FAIL %s hold_release: cpu_hold=%b expected 0 within %0d clks", tag, cpu_hold, budget);
    else n_pass++;
    exp = res_q.pop_front();
    n_total++;
    if ({load_ok, load_err} !== exp)
      $display("FAIL %s flags: ok/err=%b%b expected %b%b", tag, load_ok, load_err, exp[1], exp[0]);
    else n_pass++;
  endtask

  task automatic send_header(input string tag);
    send_byte(8'hA5, 1'b1);
    n_total++;
    if (cpu_hold !== 1'b1)
      $display("FAIL %s hold_after_hdr: cpu_hold=%b expected 1", tag, cpu_hold);
    else n_pass++;
  endtask

  // Header, 16 bytes base..base+15, then csum. Expected result comes from the
  // bench's own running sum.
  task automatic send_frame(input logic [7:0] base, input logic [7:0] csum, input string tag);
    logic [7:0] sum = 8'h00;
    logic [7:0] d;
    send_header(tag);
    for (int i = 0; i < 16; i++) begin
      d = base + 8'(i);
      send_byte(d, 1'b1);
      model_bank[~model_active][i] = d;
      sum = sum + d;
    end
    n_total++;
    if (cpu_hold !== 1'b1)
      $display("FAIL %s hold_before_csum: cpu_hold=%b expected 1", tag, cpu_hold);
    else n_pass++;
    res_q.push_back((csum == sum) ? 2'b10 : 2'b01);
    send_byte(csum, 1'b1);
    if (csum == sum) model_active = ~model_active;
    wait_result(4 * CPB * 10, tag);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    rx      = 1'b1;
    adrs    = 4'd0;
    tick(3);
    reset_n = 1'b1;
    model_reset();
    n_total++;
    if ({cpu_hold, load_ok, load_err} !== 3'b000)
      $display("FAIL reset_flags: hold/ok/err=%b%b%b expected 000", cpu_hold, load_ok, load_err);
    else n_pass++;
    n_total++;
    if (dat_out !== 8'h00)
      $display("FAIL reset_dat_out: dat_out=%02h expected 00", dat_out);
    else n_pass++;
    read_all("reset_read");
  endtask

  task automatic test_good_frame();
    send_frame(8'h10, 8'h78, "good_frame");
    read_one(4'd3, 8'h13, "good_adrs3");
    read_one(4'd15, 8'h1F, "good_adrs15");
    read_all("good_read");
  endtask

  task automatic test_bad_csum();
    send_frame(8'h10, 8'h77, "bad_csum");
    read_one(4'd3, 8'h13, "bad_csum_adrs3");
    read_all("bad_csum_read");
  endtask

  task automatic test_timeout();
    send_header("timeout");
    for (int i = 0; i < 5; i++) begin
      send_byte(8'hC0 + 8'(i), 1'b1);
      model_bank[~model_active][i] = 8'hC0 + 8'(i);
    end
    n_total++;
    if (cpu_hold !== 1'b1)
      $display("FAIL timeout hold_before_timeout: cpu_hold=%b expected 1", cpu_hold);
    else n_pass++;
    res_q.push_back(2'b01);
    wait_result(TMO + 200, "timeout");
    read_all("timeout_read");
    // 0x31..0x40 sums to 904 = 0x88 mod 256.
    send_frame(8'h31, 8'h88, "after_timeout");
    read_one(4'd0, 8'h31, "after_timeout_adrs0");
    read_all("after_timeout_read");
  endtask

  task automatic test_frame_err_glitch();
    send_header("frame_err");
    for (int i = 0; i < 2; i++) begin
      send_byte(8'h5A, 1'b1);
      model_bank[~model_active][i] = 8'h5A;
    end
    res_q.push_back(2'b01);
    send_byte(8'h55, 1'b0);
    wait_result(4 * CPB * 10, "frame_err");
    read_all("frame_err_read");
    // 2-clk low glitch while idle.
    rx = 1'b0;
    tick(2);
    rx = 1'b1;
    tick(12 * CPB);
    n_total++;
    if ({cpu_hold, load_ok, load_err} !== 3'b001)
      $display("FAIL glitch_flags: hold/ok/err=%b%b%b expected 001", cpu_hold, load_ok, load_err);
    else n_pass++;
  endtask

  task automatic test_reset_mid_frame();
    send_header("mid_reset");
    for (int i = 0; i < 3; i++) send_byte(8'hE0 + 8'(i), 1'b1);
    reset_n = 1'b0;
    tick(1);
    reset_n = 1'b1;
    model_reset();
    n_total++;
    if ({cpu_hold, load_ok, load_err} !== 3'b000)
      $display("FAIL mid_reset_flags: hold/ok/err=%b%b%b expected 000", cpu_hold, load_ok, load_err);
    else n_pass++;
    n_total++;
    if (dat_out !== 8'h00)
      $display("FAIL mid_reset_dat_out: dat_out=%02h expected 00", dat_out);
    else n_pass++;
    read_all("mid_reset_read");
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    n_total++;
    if ({cpu_hold, load_ok, load_err} !== 3'b000)
      $display("FAIL stray_bytes: hold/ok/err=%b%b%b expected 000", cpu_hold, load_ok, load_err);
    else n_pass++;
    send_frame(8'h10, 8'h78, "post_reset_frame");
    read_all("post_reset_read");
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_csum();
    test_timeout();
    test_frame_err_glitch();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_total);
    $fatal(1, "watchdog expired");
  end

endmodule
